// File: rtl/stx_pkg.sv
// rtl/stx_pkg.sv - shared constants and FSM encoding for the parametrised UART transmitter
package stx_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;
    localparam int DIV_MIN  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

endpackage

// File: rtl/stx_fifo.sv
// rtl/stx_fifo.sv - synchronous FIFO with registered full/empty flags
module stx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    // A push against a full queue is dropped even if a pop happens in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_nxt = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/stx_param.sv
// rtl/stx_param.sv - buffered UART transmitter with compile-time frame format and run-time baud divisor
module stx_param
    import stx_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_req,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic [DIV_W-1:0]     div_baud,
    output logic                 tx_ack,
    output logic                 tx_full,
    output logic                 tx_ovf,
    output logic                 tx_busy,
    output logic                 txd
);

    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_FLOOR = DIV_W'(DIV_MIN);

    state_t               state;
    logic [DIV_W-1:0]     div_q;
    logic [DIV_W-1:0]     baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] word_q;
    logic [DATA_BITS-1:0] head;
    logic                 fifo_empty;
    logic                 bit_end;
    logic                 stop_done;
    logic                 load;
    logic                 ack_q;
    logic                 par_bit;
    logic                 line_bit;

    stx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_req),
        .wdata (tx_data),
        .pop   (load),
        .rdata (head),
        .full  (tx_full),
        .empty (fifo_empty)
    );

    assign bit_end   = (baud_cnt == div_q - 1'b1);
    assign stop_done = (state == ST_STOP) & bit_end & (bit_cnt == LAST_STOP);
    assign load      = ~fifo_empty & ((state == ST_IDLE) | stop_done);
    assign par_bit   = (PARITY == PAR_EVEN) ? ^word_q : ~^word_q;
    assign tx_busy   = (state != ST_IDLE) | ~fifo_empty;

    always_comb begin
        line_bit = 1'b1;
        case (state)
            ST_START:  line_bit = 1'b0;
            ST_DATA:   line_bit = shreg[0];
            ST_PARITY: line_bit = par_bit;
            default:   line_bit = 1'b1;
        endcase
    end

    // txd and tx_ack trail the state by one cycle so both stay aligned with the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            div_q    <= DIV_FLOOR;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            word_q   <= '0;
            ack_q    <= 1'b0;
            tx_ack   <= 1'b0;
            tx_ovf   <= 1'b0;
            txd      <= 1'b1;
        end else begin
            txd    <= line_bit;
            ack_q  <= stop_done;
            tx_ack <= ack_q;
            tx_ovf <= tx_req & tx_full;
            if (load) begin
                shreg    <= head;
                word_q   <= head;
                div_q    <= (div_baud < DIV_FLOOR) ? DIV_FLOOR : div_baud;
                baud_cnt <= '0;
                bit_cnt  <= '0;
                state    <= ST_START;
            end else begin
                if (state != ST_IDLE) begin
                    baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
                end
                case (state)
                    ST_IDLE: ;
                    ST_START: begin
                        if (bit_end) state <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (bit_end) begin
                            shreg <= shreg >> 1;
                            if (bit_cnt == LAST_DATA) begin
                                bit_cnt <= '0;
                                state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (bit_end) state <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (bit_end) begin
                            if (bit_cnt == LAST_STOP) begin
                                bit_cnt <= '0;
                                state   <= ST_IDLE;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stx_param.sv
// tb/tb_stx_param.sv - directed self-checking bench for stx_param
module tb_stx_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req0 = 1'b0;
    logic [7:0]  data0 = '0;
    logic [15:0] div0 = 16'd4;
    logic        ack0, full0, ovf0, busy0, txd0;

    logic        req1 = 1'b0;
    logic [6:0]  data1 = '0;
    logic [15:0] div1 = 16'd3;
    logic        ack1, full1, ovf1, busy1, txd1;

    int tests = 0;
    int fails = 0;
    int ack_cnt0 = 0;
    int ovf_cnt0 = 0;

    always #5 clk = ~clk;

    stx_param u0 (
        .clk      (clk),
        .rst      (rst),
        .tx_req   (req0),
        .tx_data  (data0),
        .div_baud (div0),
        .tx_ack   (ack0),
        .tx_full  (full0),
        .tx_ovf   (ovf0),
        .tx_busy  (busy0),
        .txd      (txd0)
    );

    stx_param #(
        .DATA_BITS (7),
        .PARITY    (2),
        .STOP_BITS (2)
    ) u1 (
        .clk      (clk),
        .rst      (rst),
        .tx_req   (req1),
        .tx_data  (data1),
        .div_baud (div1),
        .tx_ack   (ack1),
        .tx_full  (full1),
        .tx_ovf   (ovf1),
        .tx_busy  (busy1),
        .txd      (txd1)
    );

    always @(negedge clk) begin
        if (ack0) ack_cnt0++;
        if (ovf0) ovf_cnt0++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the word is sampled at the next rising edge.
    task automatic send(input int which, input logic [8:0] d);
        if (which == 0) begin
            req0 = 1'b1;
            data0 = d[7:0];
        end else begin
            req1 = 1'b1;
            data1 = d[6:0];
        end
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic expect_frame(input int which, input logic [15:0] vec, input int nbits,
                                input int div, input string tag);
        logic bad, cur, g;
        for (int b = 0; b < nbits; b++) begin
            bad = 1'b0;
            for (int s = 0; s < div; s++) begin
                @(negedge clk);
                cur = (which == 0) ? txd0 : txd1;
                if (cur !== vec[b]) bad = 1'b1;
            end
            g = bad ? ~vec[b] : vec[b];
            check($sformatf("%s_bit%0d", tag, b), g, vec[b]);
        end
    endtask

    logic [15:0] t3_vec [5] = '{16'h200, 16'h202, 16'h204, 16'h206, 16'h208};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, o0;
        logic low_seen;

        repeat (3) @(negedge clk);
        check("rst_txd0", txd0, 1'b1);
        check("rst_ack0", ack0, 1'b0);
        check("rst_full0", full0, 1'b0);
        check("rst_ovf0", ovf0, 1'b0);
        check("rst_busy0", busy0, 1'b0);
        check("rst_txd1", txd1, 1'b1);
        check("rst_busy1", busy1, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // 1: 8N1, div 4, 0xA5
        div0 = 16'd4;
        send(0, 9'h0A5);
        check("t1_busy", busy0, 1'b1);
        @(negedge clk);
        check("t1_pre_txd", txd0, 1'b1);
        expect_frame(0, 16'h34A, 10, 4, "t1");
        check("t1_ack_early", ack0, 1'b0);
        @(negedge clk);
        check("t1_ack", ack0, 1'b1);
        check("t1_idle_txd", txd0, 1'b1);
        @(negedge clk);
        check("t1_ack_off", ack0, 1'b0);
        check("t1_busy_off", busy0, 1'b0);

        // 2: 7E2, div 3, 0x55
        div1 = 16'd3;
        send(1, 9'h055);
        @(negedge clk);
        check("t2_pre_txd", txd1, 1'b1);
        expect_frame(1, 16'h6AA, 11, 3, "t2");
        check("t2_ack_early", ack1, 1'b0);
        @(negedge clk);
        check("t2_ack", ack1, 1'b1);
        @(negedge clk);
        check("t2_ack_off", ack1, 1'b0);
        repeat (2) @(negedge clk);

        // 3: fill the queue behind a frame in flight, overflow once
        div0 = 16'd2;
        a0 = ack_cnt0;
        o0 = ovf_cnt0;
        send(0, 9'h000);
        fork
            begin
                req0 = 1'b1;
                data0 = 8'h01;
                @(negedge clk);
                data0 = 8'h02;
                @(negedge clk);
                data0 = 8'h03;
                @(negedge clk);
                check("t3_full_after3", full0, 1'b0);
                data0 = 8'h04;
                @(negedge clk);
                check("t3_full_after4", full0, 1'b1);
                data0 = 8'hFF;
                @(negedge clk);
                req0 = 1'b0;
                check("t3_ovf", ovf0, 1'b1);
                @(negedge clk);
                check("t3_ovf_off", ovf0, 1'b0);
            end
            begin
                @(negedge clk);
                for (int k = 0; k < 5; k++) begin
                    expect_frame(0, t3_vec[k], 10, 2, $sformatf("t3_f%0d", k));
                end
            end
        join
        @(negedge clk);
        check("t3_last_ack", ack0, 1'b1);
        low_seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (txd0 !== 1'b1) low_seen = 1'b1;
        end
        check("t3_no_ff_frame", low_seen, 1'b0);
        check("t3_ack_count", ack_cnt0 - a0, 5);
        check("t3_ovf_count", ovf_cnt0 - o0, 1);
        check("t3_busy_off", busy0, 1'b0);

        // 4: divisor change mid-frame applies to the next frame only
        div0 = 16'd4;
        send(0, 9'h00F);
        send(0, 9'h0F0);
        div0 = 16'd8;
        expect_frame(0, 16'h21E, 10, 4, "t4_a");
        expect_frame(0, 16'h3E0, 10, 8, "t4_b");
        @(negedge clk);
        check("t4_ack", ack0, 1'b1);
        repeat (2) @(negedge clk);

        // 5: divisor 0 clamps to 2
        div0 = 16'd0;
        send(0, 9'h03C);
        @(negedge clk);
        check("t5_pre_txd", txd0, 1'b1);
        expect_frame(0, 16'h278, 10, 2, "t5");
        @(negedge clk);
        check("t5_ack", ack0, 1'b1);
        repeat (2) @(negedge clk);

        // 6: reset during data bit 3 with one word still queued
        div0 = 16'd4;
        send(0, 9'h000);
        send(0, 9'h000);
        repeat (16) @(negedge clk);
        check("t6_pre_txd", txd0, 1'b0);
        check("t6_pre_busy", busy0, 1'b1);
        a0 = ack_cnt0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_txd", txd0, 1'b1);
        check("t6_busy", busy0, 1'b0);
        check("t6_full", full0, 1'b0);
        low_seen = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (txd0 !== 1'b1) low_seen = 1'b1;
        end
        check("t6_line_quiet", low_seen, 1'b0);
        check("t6_no_ack", ack_cnt0 - a0, 0);
        check("t6_busy_after", busy0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stx_param.md
Name: stx_param

Overview:
Parametrised, buffered UART transmitter for the smonitor serial path. It is the next generation of the fixed 8N1 transmitter. Data width, parity mode, stop-bit count and FIFO depth are compile-time parameters, and the baud divisor is a run-time input. Bytes are queued in a small FIFO and sent back-to-back with no idle gap. Each completed frame raises a one-cycle acknowledge.

Parameters:
DATA_BITS, 8, data bits per frame (legal 5..9)
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame (legal 1 or 2)
DIV_W, 16, width of the baud divisor input
FIFO_DEPTH, 4, queue entries (power of two, >= 2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
tx_req  input  1  single-cycle write strobe
tx_data  input  DATA_BITS  word to queue; sampled when tx_req=1
div_baud  input  DIV_W  clk cycles per serial bit; sampled at frame start
tx_ack  output  1  one-cycle pulse at the end of each frame's last stop bit
tx_full  output  1  FIFO full
tx_ovf  output  1  one-cycle pulse when tx_req arrives while full
tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty
txd  output  1  serial line, idle high

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values: txd=1, tx_ack=0, tx_full=0, tx_ovf=0, tx_busy=0. FIFO is emptied, FSM goes to IDLE, all counters are 0.
- Reset mid-frame: the frame is aborted, txd=1 from the next edge, and no tx_ack is raised.
- Write when tx_req=1 and tx_full=0: tx_data is pushed. tx_full is registered and updates the cycle after the push.
- Write when tx_req=1 and tx_full=1: the word is dropped and tx_ovf=1 on the next cycle. A pop in the same cycle does not rescue the write.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE with FIFO non-empty:
  - pop the head into the shift register;
  - latch the divisor as div = max(div_baud, 2);
  - clear the baud counter; go to START.
- Bit timing: the baud counter restarts at every frame start. Each bit lasts exactly div cycles. State advances when the counter equals div-1.
- START: txd=0.
- DATA: txd = shift register bit 0; shift right each bit. DATA_BITS bits are sent LSB first.
- DATA exit: go to PARITY if PARITY != 0, otherwise go to STOP.
- PARITY: txd = XOR of the data word for even, inverted XOR for odd. Parity is computed from the popped word, not from the shifting register.
- STOP: txd=1 for STOP_BITS*div cycles.
- Last STOP cycle:
  - tx_ack=1 on the next edge;
  - if the FIFO is non-empty, pop and go straight to START with no idle bit;
  - otherwise go to IDLE.
- Latency: with FSM in IDLE and the FIFO empty, a tx_req sampled at edge 0 pushes at edge 0. txd falls at edge 2.
- Frame length: div*(1 + DATA_BITS + (PARITY != 0) + STOP_BITS) cycles.
- div_baud changes mid-frame have no effect until the next frame start.
- txd is registered; there is no combinational path from inputs to txd.
- tx_busy = (state != IDLE) | fifo_not_empty.

Decomposition:
- Package stx_pkg holds:
  - the parity-mode constants PAR_NONE, PAR_ODD and PAR_EVEN;
  - the FSM state encodings;
  - the minimum divisor constant DIV_MIN = 2.
- One sub-module, stx_fifo: synchronous FIFO parametrised by width and depth, with push/pop/full/empty and a registered read pointer.
- The FSM, baud counter, bit counter and shifter live in stx_param.

Test Plan:
1. Defaults, div_baud=4, tx_req with 0xA5:
   - txd pattern of 4-cycle bits 0,1,0,1,0,0,1,0,1,1 (start, data LSB first, stop);
   - frame 40 cycles long;
   - txd falls 2 cycles after the request;
   - tx_ack one cycle after the stop bit ends.
2. PARITY=2, STOP_BITS=2, DATA_BITS=7, div=3, data 0x55:
   - parity bit = 0;
   - stop held 6 cycles;
   - frame 33 cycles long.
3. Write 4 words 0x01..0x04 in consecutive cycles, then a 5th (0xFF) while full:
   - tx_full=1 after the 4th write;
   - tx_ovf pulses once and 0xFF is never sent;
   - the four frames are contiguous with no idle bit between them;
   - 4 tx_ack pulses.
4. Change div_baud from 4 to 8 mid-frame: current frame stays at 4-cycle bits; the next frame uses 8-cycle bits.
5. div_baud=0: bits last 2 cycles.
6. Assert rst during DATA bit 3: txd=1 the next cycle, no tx_ack, tx_busy=0, FIFO empty.
